// File: rtl/serial_deser_pkg.sv
// Purpose: shared FSM encoding and line-level constants for the serial frame deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_deser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Line idles low; a 1 marks the start of a frame and a 0 closes it.
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // Even parity: XOR of data bits and parity bit must come out to this value.
  localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/word_holding_reg.sv
// Purpose: single-entry output buffer for assembled words with valid/ready handshake.
// Latency: a load request on edge k shows q_valid/Q after edge k.
// Backpressure: loads only when empty or draining this edge; otherwise drops and pulses overrun.
module word_holding_reg #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_req,
  input  logic [n-1:0] load_dat,
  input  logic         q_ready,
  output logic [n-1:0] Q,
  output logic         q_valid,
  output logic         overrun
);

  logic drain;
  logic accept;

  assign drain  = q_valid && q_ready;
  assign accept = load_req && (!q_valid || drain);

  // Hold the word until consumed; a same-edge drain frees the slot for a new load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= load_req && !accept;
      if (accept) begin
        Q       <= load_dat;
        q_valid <= 1'b1;
      end else if (drain) begin
        q_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Purpose: frames start/n data/[parity]/stop serial bits into words, LSB- or MSB-first; parity via PARITY_CHECK_EN.
// Latency: q_valid rises right after the edge that samples a good stop bit.
// Backpressure: si_valid=0 stalls the FSM; a good word arriving at a full holding register is dropped with overrun.
module serial_frame_deserializer #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         SI,
  input  logic         si_valid,
  input  logic         R_L_n,
  output logic [n-1:0] Q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         frame_err,
  output logic         parity_err,
  output logic         overrun
);

  import serial_deser_pkg::*;

  localparam int CNT_W = (n > 1) ? $clog2(n) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(n - 1);

  state_t           state;
  logic [n-1:0]     shreg;
  logic [CNT_W-1:0] cnt;
  logic             ord_q;
  logic             stop_ok;
  logic             parity_ok;
  logic             commit;

  assign stop_ok = (SI == STOP_BIT);

`ifdef PARITY_CHECK_EN
  logic par_bit;
  logic parity_err_q;

  assign parity_ok  = (((^shreg) ^ par_bit) == PARITY_EVEN);
  assign parity_err = parity_err_q;
`else
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Commit is decided combinationally on the stop-bit edge so the word lands in the holding register on that edge.
  assign commit = si_valid && (state == ST_STOP) && stop_ok && parity_ok;

  // Frame FSM, shift register and bit counter; error flags are one-cycle registered pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      ord_q     <= 1'b0;
      frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
      if (si_valid) begin
        case (state)
          ST_IDLE: begin
            if (SI == START_BIT) begin
              state <= ST_DATA;
              ord_q <= R_L_n;
              cnt   <= '0;
            end
          end
          ST_DATA: begin
            // LSB-first enters at the top so the first bit ends in bit 0; MSB-first is the mirror.
            if (ord_q) shreg <= {SI, shreg[n-1:1]};
            else       shreg <= {shreg[n-2:0], SI};
            if (cnt == LAST_CNT) begin
              cnt <= '0;
`ifdef PARITY_CHECK_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_PARITY: begin
`ifdef PARITY_CHECK_EN
            par_bit <= SI;
`endif
            state <= ST_STOP;
          end
          ST_STOP: begin
            // A 1 in the stop slot is an error only; it never doubles as the next start bit.
            frame_err <= !stop_ok;
`ifdef PARITY_CHECK_EN
            parity_err_q <= !parity_ok;
`endif
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  word_holding_reg #(.n(n)) u_hold (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_req (commit),
    .load_dat (shreg),
    .q_ready  (q_ready),
    .Q        (Q),
    .q_valid  (q_valid),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Purpose: directed bench for serial_frame_deserializer with a word scoreboard and pulse counters.
// Latency: expects words right after the stop-bit edge.
// Backpressure: exercises held words, overrun and stalls via si_valid.
module tb_serial_frame_deserializer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         SI = 1'b0;
  logic         si_valid = 1'b0;
  logic         R_L_n = 1'b1;
  logic         q_ready = 1'b0;
  logic [N-1:0] Q;
  logic         q_valid;
  logic         frame_err;
  logic         parity_err;
  logic         overrun;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] exp_words[$];
  int exp_ferr = 0, obs_ferr = 0;
  int exp_perr = 0, obs_perr = 0;
  int exp_ovr  = 0, obs_ovr  = 0;

  serial_frame_deserializer #(.n(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .SI         (SI),
    .si_valid   (si_valid),
    .R_L_n      (R_L_n),
    .Q          (Q),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, pops expected words on each handshake and counts flag pulses.
  initial begin
    logic [N-1:0] w;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (q_valid && q_ready) begin
          if (exp_words.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%0h required=none", Q);
          end else begin
            w = exp_words.pop_front();
            check("word", {28'd0, Q}, {28'd0, w});
          end
        end
        if (frame_err) begin
          obs_ferr++;
          if (obs_ferr > exp_ferr) begin
            checks++; failures++;
            $display("FAIL unexpected_frame_err actual=%0d required=%0d", obs_ferr, exp_ferr);
          end
        end
        if (parity_err) begin
          obs_perr++;
          if (obs_perr > exp_perr) begin
            checks++; failures++;
            $display("FAIL unexpected_parity_err actual=%0d required=%0d", obs_perr, exp_perr);
          end
        end
        if (overrun) begin
          obs_ovr++;
          if (obs_ovr > exp_ovr) begin
            checks++; failures++;
            $display("FAIL unexpected_overrun actual=%0d required=%0d", obs_ovr, exp_ovr);
          end
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    SI = b;
    si_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // bits[0] is sent first.
  task automatic send_frame(input logic [N-1:0] bits, input logic rl, input logic bad_par, input logic stop_b);
    logic p;
    p = (^bits) ^ bad_par;
    R_L_n = rl;
    send_bit(1'b1);
    for (int i = 0; i < N; i++) send_bit(bits[i]);
`ifdef PARITY_CHECK_EN
    send_bit(p);
`endif
    send_bit(stop_b);
    SI = 1'b0;
  endtask

  task automatic drain();
    q_ready = 1'b1;
    @(posedge clk);
    #1;
    q_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_Q", {28'd0, Q}, 32'd0);
    check("rst_q_valid", {31'd0, q_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1. Word held, then reset mid-frame clears it and discards the partial frame.
    send_frame(4'b1101, 1'b1, 1'b0, 1'b0);
    check("t1_pre_Q", {28'd0, Q}, 32'hD);
    check("t1_pre_q_valid", {31'd0, q_valid}, 32'd1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_n = 1'b0;
    #1;
    check("t1_mid_rst_Q", {28'd0, Q}, 32'd0);
    check("t1_mid_rst_q_valid", {31'd0, q_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    exp_words.push_back(4'b1101);
    send_frame(4'b1101, 1'b1, 1'b0, 1'b0);
    drain();
    check("t1_drained", {31'd0, q_valid}, 32'd0);

    // 2. MSB-first: stream 1,0,1,1 gives 1011; q_valid only after the stop edge.
    exp_words.push_back(4'b1011);
    R_L_n = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
`ifdef PARITY_CHECK_EN
    send_bit(1'b1);
`endif
    check("t2_qv_before_stop", {31'd0, q_valid}, 32'd0);
    send_bit(1'b0);
    SI = 1'b0;
    check("t2_qv_after_stop", {31'd0, q_valid}, 32'd1);
    check("t2_Q", {28'd0, Q}, 32'hB);
    drain();
    exp_words.push_back(4'b1100);
    send_frame(4'b0011, 1'b0, 1'b0, 1'b0);
    drain();

    // 3. Backpressure: second good word overruns, first one held.
    exp_words.push_back(4'b1101);
    send_frame(4'b1101, 1'b1, 1'b0, 1'b0);
    exp_ovr++;
    send_frame(4'b0110, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("t3_Q_held", {28'd0, Q}, 32'hD);
    check("t3_qv_held", {31'd0, q_valid}, 32'd1);
    drain();
    check("t3_qv_drop", {31'd0, q_valid}, 32'd0);

    // 4. Bad stop, then 0,0 must not start a frame.
    exp_ferr++;
    send_frame(4'b0110, 1'b1, 1'b0, 1'b1);
    check("t4_qv_after_bad_stop", {31'd0, q_valid}, 32'd0);
    send_bit(1'b0);
    send_bit(1'b0);
    check("t4_qv_after_zeros", {31'd0, q_valid}, 32'd0);
    exp_words.push_back(4'b0011);
    send_frame(4'b0011, 1'b1, 1'b0, 1'b0);
    drain();

    // 5. Stall mid-DATA while toggling R_L_n; order latched at start (LSB-first).
    exp_words.push_back(4'b0011);
    R_L_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    si_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      SI = ~SI;
      R_L_n = ~R_L_n;
      @(posedge clk);
      #1;
    end
    R_L_n = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
`ifdef PARITY_CHECK_EN
    send_bit(1'b0);
`endif
    send_bit(1'b0);
    SI = 1'b0;
    R_L_n = 1'b1;
    drain();

`ifdef PARITY_CHECK_EN
    // 6. Parity: 1,1,1,0 with parity 0 is bad, with parity 1 good.
    exp_perr++;
    send_frame(4'b0111, 1'b1, 1'b1, 1'b0);
    check("t6_qv_bad_par", {31'd0, q_valid}, 32'd0);
    exp_words.push_back(4'b0111);
    send_frame(4'b0111, 1'b1, 1'b0, 1'b0);
    drain();
    exp_perr++;
    exp_ferr++;
    send_frame(4'b0111, 1'b1, 1'b1, 1'b1);
    check("t6_qv_both_bad", {31'd0, q_valid}, 32'd0);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("frame_err_count", obs_ferr, exp_ferr);
    check("parity_err_count", obs_perr, exp_perr);
    check("overrun_count", obs_ovr, exp_ovr);
    check("words_outstanding", exp_words.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
